// File: rtl/ts_checker_if.sv
// ts_if: MPEG-TS byte stream in, lock/PID/statistics out, for one ts_checker.
interface ts_if #(
  parameter int unsigned CNT_W = 16
);
  logic [7:0]       DATA;
  logic             D_VALID;
  logic             P_SYNC;
  logic [12:0]      PID_SEL;
  logic             LOCKED;
  logic [12:0]      PID_OUT;
  logic             PKT_DONE;
  logic             CC_ERR;
  logic [CNT_W-1:0] PKT_CNT;
  logic [CNT_W-1:0] SYNC_ERR_CNT;
  logic [CNT_W-1:0] CC_ERR_CNT;
  logic [CNT_W-1:0] PL_ERR_CNT;

  modport master (
    output DATA, D_VALID, P_SYNC, PID_SEL,
    input  LOCKED, PID_OUT, PKT_DONE, CC_ERR,
    input  PKT_CNT, SYNC_ERR_CNT, CC_ERR_CNT, PL_ERR_CNT
  );

  modport slave (
    input  DATA, D_VALID, P_SYNC, PID_SEL,
    output LOCKED, PID_OUT, PKT_DONE, CC_ERR,
    output PKT_CNT, SYNC_ERR_CNT, CC_ERR_CNT, PL_ERR_CNT
  );
endinterface

// File: rtl/ts_checker.sv
// ts_checker: MPEG-TS receive monitor. Hunts for sync, locks after LOCK_PKTS good
// packets, extracts PID, checks continuity counter of the selected PID and keeps
// saturating statistics. Optional loopback payload compare: TS_PAYLOAD_CHECK_EN.
module ts_checker #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOCK_PKTS = 3
) (
  input logic CLK,
  input logic RST,
  ts_if.slave bus
);

  localparam int unsigned IDX_W   = 8;
  localparam int unsigned LOCK_W  = 4;
  localparam int unsigned PKT_LEN = 188;
  localparam logic [7:0]        SYNC_BYTE = 8'h47;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_LEN - 1);
  localparam logic [LOCK_W-1:0] LOCK_TGT  = LOCK_W'(LOCK_PKTS);

  typedef enum logic [1:0] {S_HUNT, S_HDR, S_PAYLOAD, S_EXPECT} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx;
  logic [4:0]        pid_hi;
  logic [7:0]        pid_lo;
  logic [12:0]       sel_lat;
  logic [3:0]        cc_rx;
  logic              pl_flag;
  logic [3:0]        cc_prev;
  logic              cc_valid;
  logic [LOCK_W-1:0] lock_cnt;
  logic              locked;
  logic [12:0]       pid_out;
  logic              pkt_done;
  logic              cc_err;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [CNT_W-1:0]  sync_cnt;
  logic [CNT_W-1:0]  cc_cnt;

  logic              is_start_c;
  logic              hdr_byte_c;
  logic              hdr_start;
  logic              sync_err;
  logic              pkt_good;
  logic [12:0]       pkt_pid_c;
  logic              sel_hit_c;
  logic [3:0]        cc_exp_c;
  logic              cc_mis_c;
  logic [LOCK_W-1:0] lock_cnt_n_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign is_start_c   = bus.P_SYNC && (bus.DATA == SYNC_BYTE);
  assign hdr_byte_c   = bus.D_VALID && (state == S_HDR) && !bus.P_SYNC;
  assign pkt_pid_c    = {pid_hi, pid_lo};
  assign sel_hit_c    = (pkt_pid_c == sel_lat);
  assign cc_exp_c     = pl_flag ? cc_prev + 4'd1 : cc_prev;
  assign cc_mis_c     = pkt_good && sel_hit_c && cc_valid && (cc_rx != cc_exp_c);
  assign lock_cnt_n_c = (lock_cnt >= LOCK_TGT) ? lock_cnt : lock_cnt + LOCK_W'(1);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_HUNT;
    else      state <= state_n;
  end

  // Next state and per-byte events; only D_VALID cycles can move the FSM
  always_comb begin
    state_n   = state;
    hdr_start = 1'b0;
    sync_err  = 1'b0;
    pkt_good  = 1'b0;
    if (bus.D_VALID) begin
      case (state)
        S_HUNT: begin
          if (is_start_c) begin
            state_n   = S_HDR;
            hdr_start = 1'b1;
          end else if (bus.P_SYNC) begin
            sync_err = 1'b1;
          end
        end
        S_HDR, S_PAYLOAD: begin
          if (bus.P_SYNC) begin
            sync_err = 1'b1;
            if (is_start_c) begin
              state_n   = S_HDR;
              hdr_start = 1'b1;
            end else begin
              state_n = S_HUNT;
            end
          end else if ((state == S_HDR) && (idx == IDX_W'(3))) begin
            state_n = S_PAYLOAD;
          end else if ((state == S_PAYLOAD) && (idx == LAST_IDX)) begin
            pkt_good = 1'b1;
            state_n  = S_EXPECT;
          end
        end
        S_EXPECT: begin
          if (is_start_c) begin
            state_n   = S_HDR;
            hdr_start = 1'b1;
          end else begin
            sync_err = 1'b1;
            state_n  = S_HUNT;
          end
        end
        default: state_n = S_HUNT;
      endcase
    end
  end

  // Byte index within the current packet (sync byte is index 0)
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx <= '0;
    end else if (hdr_start) begin
      idx <= IDX_W'(1);
    end else if (sync_err || pkt_good) begin
      idx <= '0;
    end else if (bus.D_VALID && !bus.P_SYNC && ((state == S_HDR) || (state == S_PAYLOAD))) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Header field capture: PID, selected PID, CC and payload flag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pid_hi  <= '0;
      pid_lo  <= '0;
      sel_lat <= '0;
      cc_rx   <= '0;
      pl_flag <= 1'b0;
    end else if (hdr_byte_c) begin
      if (idx == IDX_W'(1)) pid_hi <= bus.DATA[4:0];
      if (idx == IDX_W'(2)) begin
        pid_lo  <= bus.DATA;
        sel_lat <= bus.PID_SEL;
      end
      if (idx == IDX_W'(3)) begin
        cc_rx   <= bus.DATA[3:0];
        pl_flag <= bus.DATA[4];
      end
    end
  end

  // Continuity reference for the selected PID; dropped on sync loss or PID_SEL change
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cc_prev  <= '0;
      cc_valid <= 1'b0;
    end else if (sync_err) begin
      cc_valid <= 1'b0;
    end else if (pkt_good && sel_hit_c) begin
      cc_prev  <= cc_rx;
      cc_valid <= 1'b1;
    end else if (hdr_byte_c && (idx == IDX_W'(2)) && (bus.PID_SEL != sel_lat)) begin
      cc_valid <= 1'b0;
    end
  end

  // Lock tracking and per-packet output pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
      pid_out  <= '0;
      pkt_done <= 1'b0;
      cc_err   <= 1'b0;
    end else begin
      pkt_done <= pkt_good;
      cc_err   <= cc_mis_c;
      if (pkt_good) pid_out <= pkt_pid_c;
      if (sync_err) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (pkt_good) begin
        lock_cnt <= lock_cnt_n_c;
        if (lock_cnt_n_c >= LOCK_TGT) locked <= 1'b1;
      end
    end
  end

  // Saturating statistics
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pkt_cnt  <= '0;
      sync_cnt <= '0;
      cc_cnt   <= '0;
    end else begin
      if (pkt_good) pkt_cnt  <= sat_inc(pkt_cnt);
      if (sync_err) sync_cnt <= sat_inc(sync_cnt);
      if (cc_mis_c) cc_cnt   <= sat_inc(cc_cnt);
    end
  end

`ifdef TS_PAYLOAD_CHECK_EN
  logic             pl_bad;
  logic             pl_mis_c;
  logic             pl_hit_c;
  logic [CNT_W-1:0] pl_cnt;

  assign pl_mis_c = bus.D_VALID && (state == S_PAYLOAD) && !bus.P_SYNC && (bus.DATA != pid_lo);
  assign pl_hit_c = pkt_good && sel_hit_c && (pl_bad || pl_mis_c);

  // Sticky per-packet payload mismatch flag against the loopback pattern PID[7:0]
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)          pl_bad <= 1'b0;
    else if (hdr_start) pl_bad <= 1'b0;
    else if (pl_mis_c)  pl_bad <= 1'b1;
  end

  // One payload error count per bad packet, at completion
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         pl_cnt <= '0;
    else if (pl_hit_c) pl_cnt <= sat_inc(pl_cnt);
  end

  assign bus.PL_ERR_CNT = pl_cnt;
`else
  assign bus.PL_ERR_CNT = '0;
`endif

  assign bus.LOCKED       = locked;
  assign bus.PID_OUT      = pid_out;
  assign bus.PKT_DONE     = pkt_done;
  assign bus.CC_ERR       = cc_err;
  assign bus.PKT_CNT      = pkt_cnt;
  assign bus.SYNC_ERR_CNT = sync_cnt;
  assign bus.CC_ERR_CNT   = cc_cnt;

endmodule

// File: tb/tb_ts_checker.sv
// tb_ts_checker: randomized packet-level stimulus against a packet-level reference
// model. A second instance with 2-bit counters and LOCK_PKTS=1 exercises saturation.
module tb_ts_checker;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LOCK_PKTS = 3;
  localparam int unsigned SCNT_W    = 2;
  localparam int          SAT_MAX   = 3;

  logic CLK = 1'b0;
  logic RST;

  ts_if #(.CNT_W(CNT_W))  bus ();
  ts_if #(.CNT_W(SCNT_W)) sbus ();

  assign sbus.DATA    = bus.DATA;
  assign sbus.D_VALID = bus.D_VALID;
  assign sbus.P_SYNC  = bus.P_SYNC;
  assign sbus.PID_SEL = bus.PID_SEL;

  ts_checker #(.CNT_W(CNT_W), .LOCK_PKTS(LOCK_PKTS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  ts_checker #(.CNT_W(SCNT_W), .LOCK_PKTS(1)) dut_sat (
    .CLK (CLK),
    .RST (RST),
    .bus (sbus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (packet level)
  int          m_pkt, m_sync, m_cc, m_pl, m_lock;
  logic [12:0] m_pid_out, m_last_sel;
  logic [3:0]  m_cc_prev;
  bit          m_cc_valid, m_pending;
  int          tot_done = 0, tot_ccerr = 0;
  int          mon_done = 0, mon_ccerr = 0;
  bit          gap_en = 1'b0;
  logic [12:0] cur_sel;
  logic [12:0] pid_pool [4] = '{13'h0100, 13'h1FFF, 13'h0000, 13'h00A5};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT_MAX) ? SAT_MAX : v;
  endfunction

  // Count output pulses independently of the per-packet checks
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (bus.PKT_DONE === 1'b1) mon_done++;
      if (bus.CC_ERR === 1'b1)   mon_ccerr++;
    end
  end

  task automatic model_reset();
    m_pkt = 0; m_sync = 0; m_cc = 0; m_pl = 0; m_lock = 0;
    m_pid_out = '0; m_last_sel = '0; m_cc_prev = '0;
    m_cc_valid = 1'b0; m_pending = 1'b0;
  endtask

  task automatic model_sync_err();
    m_sync++;
    m_lock = 0;
    m_cc_valid = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic s);
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge CLK);
        bus.D_VALID = 1'b0;
        bus.DATA    = 8'($urandom);
        bus.P_SYNC  = 1'($urandom);
      end
    end
    @(negedge CLK);
    bus.D_VALID = 1'b1;
    bus.DATA    = d;
    bus.P_SYNC  = s;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pkt_cnt"}, 32'(bus.PKT_CNT), 32'(m_pkt));
    check_val({tag, ".sync_cnt"}, 32'(bus.SYNC_ERR_CNT), 32'(m_sync));
    check_val({tag, ".cc_cnt"}, 32'(bus.CC_ERR_CNT), 32'(m_cc));
    check_val({tag, ".pl_cnt"}, 32'(bus.PL_ERR_CNT), 32'(m_pl));
    check_val({tag, ".locked"}, 32'(bus.LOCKED), 32'(m_lock >= int'(LOCK_PKTS)));
    check_val({tag, ".pid_out"}, 32'(bus.PID_OUT), 32'(m_pid_out));
    check_val({tag, ".sat_pkt"}, 32'(sbus.PKT_CNT), 32'(sat(m_pkt)));
    check_val({tag, ".sat_sync"}, 32'(sbus.SYNC_ERR_CNT), 32'(sat(m_sync)));
    check_val({tag, ".sat_cc"}, 32'(sbus.CC_ERR_CNT), 32'(sat(m_cc)));
    check_val({tag, ".sat_pl"}, 32'(sbus.PL_ERR_CNT), 32'(sat(m_pl)));
    check_val({tag, ".sat_locked"}, 32'(sbus.LOCKED), 32'(m_lock >= 1));
  endtask

  // Full 188-byte packet with loopback payload; expected results from the model
  task automatic send_good(input logic [12:0] pid, input logic [3:0] cc,
                           input logic flag, input bit corrupt);
    int   cpos;
    bit   exp_ccerr;
    logic [7:0] b;
    cpos = $urandom_range(4, 187);
    drive_byte(8'h47, 1'b1);
    drive_byte({3'($urandom), pid[12:8]}, 1'b0);
    drive_byte(pid[7:0], 1'b0);
    drive_byte({3'($urandom), flag, cc}, 1'b0);
    for (int i = 4; i < 188; i++) begin
      b = pid[7:0];
      if (corrupt && i == cpos) b = b ^ 8'h5A;
      drive_byte(b, 1'b0);
    end
    if (m_pending) model_sync_err();
    m_pending = 1'b0;
    if (cur_sel != m_last_sel) m_cc_valid = 1'b0;
    m_last_sel = cur_sel;
    m_pkt++;
    m_lock++;
    m_pid_out = pid;
    exp_ccerr = 1'b0;
    if (pid == cur_sel) begin
      if (m_cc_valid) exp_ccerr = (cc != (flag ? m_cc_prev + 4'd1 : m_cc_prev));
      m_cc_prev  = cc;
      m_cc_valid = 1'b1;
`ifdef TS_PAYLOAD_CHECK_EN
      if (corrupt) m_pl++;
`endif
    end
    if (exp_ccerr) begin
      m_cc++;
      tot_ccerr++;
    end
    tot_done++;
    @(posedge CLK);
    #1;
    check_val("pkt_done", 32'(bus.PKT_DONE), 32'd1);
    check_val("cc_err", 32'(bus.CC_ERR), 32'(exp_ccerr));
    check_all("good");
  endtask

  // Packet cut short by the next sync byte
  task automatic send_trunc(input int len);
    if (m_pending) model_sync_err();
    m_pending = 1'b1;
    drive_byte(8'h47, 1'b1);
    for (int i = 1; i < len; i++) drive_byte(8'($urandom), 1'b0);
  endtask

  // P_SYNC on a non-0x47 byte, followed by unmarked garbage that must be ignored
  task automatic send_badsync();
    logic [7:0] d;
    d = 8'($urandom);
    if (d == 8'h47) d = 8'h46;
    drive_byte(d, 1'b1);
    model_sync_err();
    m_pending = 1'b0;
    @(posedge CLK);
    #1;
    check_val("badsync.sync_cnt", 32'(bus.SYNC_ERR_CNT), 32'(m_sync));
    check_val("badsync.locked", 32'(bus.LOCKED), 32'd0);
    repeat ($urandom_range(0, 5)) drive_byte(8'($urandom), 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".locked"}, 32'(bus.LOCKED), 32'd0);
    check_val({tag, ".pid_out"}, 32'(bus.PID_OUT), 32'd0);
    check_val({tag, ".pkt_done"}, 32'(bus.PKT_DONE), 32'd0);
    check_val({tag, ".cc_err"}, 32'(bus.CC_ERR), 32'd0);
    check_val({tag, ".counts"},
              32'({bus.PKT_CNT, bus.SYNC_ERR_CNT} | {bus.CC_ERR_CNT, bus.PL_ERR_CNT}), 32'd0);
  endtask

  // Asynchronous reset in the middle of a packet
  task automatic reset_mid(input int len);
    drive_byte(8'h47, 1'b1);
    for (int i = 1; i < len; i++) drive_byte(cur_sel[7:0], 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check_zero("rst");
    @(negedge CLK);
    bus.D_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    model_reset();
  endtask

  task automatic random_good(input bit corrupt);
    logic [12:0] pid;
    logic        flag;
    logic [3:0]  cc;
    pid  = ($urandom_range(0, 9) < 6) ? cur_sel : pid_pool[$urandom_range(0, 3)];
    flag = ($urandom_range(0, 4) != 0);
    cc   = ($urandom_range(0, 3) != 0) ? m_cc_prev + 4'(flag) : 4'($urandom);
    send_good(pid, cc, flag, corrupt);
  endtask

  initial begin
    RST         = 1'b1;
    bus.D_VALID = 1'b0;
    bus.DATA    = '0;
    bus.P_SYNC  = 1'b0;
    cur_sel     = 13'h0100;
    bus.PID_SEL = cur_sel;
    model_reset();
    #2 RST = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Directed: bad first sync, lock, CC sequence, wrap, pl_flag=0, payload, short packet
    send_badsync();
    send_good(13'h0100, 4'h0, 1'b1, 1'b0);
    send_good(13'h0100, 4'h1, 1'b1, 1'b0);
    send_good(13'h0100, 4'h2, 1'b1, 1'b0);
    send_good(13'h0100, 4'h4, 1'b1, 1'b0);
    send_good(13'h0100, 4'h5, 1'b1, 1'b0);
    send_good(13'h0100, 4'hF, 1'b1, 1'b0);
    send_good(13'h0100, 4'h0, 1'b1, 1'b0);
    send_good(13'h0100, 4'h0, 1'b0, 1'b0);
    send_good(13'h0100, 4'h1, 1'b0, 1'b0);
    send_good(13'h0100, 4'h2, 1'b1, 1'b1);
    send_trunc(100);
    send_good(13'h0100, 4'h3, 1'b1, 1'b0);
    gap_en = 1'b1;
    send_good(13'h0100, 4'h4, 1'b1, 1'b0);
    reset_mid(60);
    send_good(13'h0100, 4'h5, 1'b1, 1'b0);
    send_good(13'h0100, 4'h6, 1'b1, 1'b0);
    send_good(13'h0100, 4'h7, 1'b1, 1'b0);

    // Randomized segments
    for (int seg = 0; seg < 50; seg++) begin
      int r;
      if ($urandom_range(0, 9) == 0) gap_en = ~gap_en;
      if ($urandom_range(0, 14) == 0) begin
        cur_sel     = pid_pool[$urandom_range(0, 3)];
        bus.PID_SEL = cur_sel;
      end
      r = $urandom_range(0, 99);
      if (r < 62)      random_good(1'b0);
      else if (r < 75) send_trunc($urandom_range(1, 187));
      else if (r < 87) send_badsync();
      else if (r < 90) reset_mid($urandom_range(1, 187));
      else             random_good(1'b1);
    end
    random_good(1'b0);
    random_good(1'b0);

    @(negedge CLK);
    bus.D_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("total_done", 32'(mon_done), 32'(tot_done));
    check_val("total_ccerr", 32'(mon_ccerr), 32'(tot_ccerr));
    check_all("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
